spi_reg_ctrl: RTL and testbench
===============================

Name: spi_reg_ctrl

Overview:
Transaction controller behind the SPI slave byte interface. It parses each chip-select frame as one command byte followed by data bytes. It then sequences single-beat accesses on an internal register bus: writes for write commands, read-prefetch into the slave's tx_data for read commands. It also tracks the burst address, handshake timeouts and overrun errors.

Parameters:
AUTO_INC, 1, 1 = increment reg_addr (mod 128) after every completed data beat; 0 = fixed address
TIMEOUT, 15, clk cycles reg_req may stay high without reg_ack before abort (4-bit counter, 1..15)
IDLE_TX, 8'hA5, value driven on tx_data when no read data is pending

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
spi_busy  in  1  slave frame active (CS asserted, synchronised)
rx_data  in  8  byte received from slave
rx_valid  in  1  1-cycle strobe, rx_data valid
tx_data  out  8  next byte for slave to shift out
tx_valid  out  1  tx_data holds fresh register read data
tx_ready  in  1  1-cycle strobe, slave latched tx_data
reg_addr  out  7  register bus address
reg_wdata  out  8  register bus write data
reg_we  out  1  1 = write, 0 = read; valid while reg_req
reg_req  out  1  request, held until reg_ack or timeout
reg_ack  in  1  1-cycle completion strobe; reg_rdata valid same cycle for reads
reg_rdata  in  8  read data
clr_err  in  1  clears sticky error flags
err_overrun  out  1  sticky: byte arrived while write beat outstanding
err_timeout  out  1  sticky: reg_ack not seen within TIMEOUT
frame_done  out  1  1-cycle pulse on every spi_busy falling edge seen by this block

Behaviour:
- Reset values: tx_data=IDLE_TX; reg_addr, reg_wdata=0; tx_valid, reg_we, reg_req, err_*, frame_done=0; state=IDLE.
- Registers: all outputs are registered. spi_busy is sampled into a 1-bit history register for edge detection.
- States: IDLE, CMD, WR_DATA, WR_BUS, RD_BUS, RD_HOLD.
- IDLE: on spi_busy rising edge -> CMD. tx_data=IDLE_TX, tx_valid=0.
- CMD: on rx_valid, reg_addr<=rx_data[6:0].
  - rx_data[7]=0 -> WR_DATA.
  - rx_data[7]=1 -> RD_BUS, with reg_req=1 and reg_we=0 asserted the next cycle.
- WR_DATA: on rx_valid, reg_wdata<=rx_data, then reg_req=1, reg_we=1 -> WR_BUS.
- WR_BUS: on reg_ack, drop reg_req. Increment addr if AUTO_INC. -> WR_DATA.
  - rx_valid in WR_BUS: byte dropped, err_overrun<=1.
  - rx_valid coincident with reg_ack is also an overrun.
- RD_BUS: on reg_ack, tx_data<=reg_rdata, tx_valid<=1, drop reg_req -> RD_HOLD. rx_valid bytes are ignored (dummy).
- RD_HOLD: on tx_ready, tx_valid<=0 and increment addr if AUTO_INC, then reissue the read -> RD_BUS. rx_valid is ignored.
  - If tx_ready arrives in RD_BUS, no effect: the slave sends stale data by design.
- Latency: reg_req rises 1 cycle after the triggering rx_valid or tx_ready. tx_data updates the cycle after reg_ack.
- Timeout: a 4-bit counter runs while reg_req=1.
  - At TIMEOUT without reg_ack: reg_req<=0, err_timeout<=1, state -> IDLE.
  - Remaining bytes of the frame are ignored until the next spi_busy rising edge.
- Frame end: spi_busy falling edge in any state -> IDLE next cycle. Also:
  - frame_done pulses 1 cycle.
  - tx_valid<=0 and tx_data<=IDLE_TX.
  - An outstanding reg_req is kept until reg_ack or timeout, and no further beats are issued. A late ack completes the write or discards the read data.
  - A new frame starting while a request is still outstanding waits in CMD.
  - The command byte is accepted only after reg_req drops. Earlier bytes set err_overrun.
- Errors: err_* are sticky until clr_err. If clr_err and a new error occur in the same cycle, the set wins.
- Address wrap: 7'h7F + 1 -> 7'h00.

Test Plan:
- Write burst: frame bytes 0x05,0x11,0x22 with reg_ack 2 cycles after each reg_req -> writes (05,11), (06,22) with reg_we=1; frame_done pulses once; err_*=0.
- Read burst: frame 0x85, reg_rdata=addr XOR 0x3C, tx_ready pulsed twice -> reads at 05, 06, 07; tx_data sequence 0x39, 0x3A, 0x3B with tx_valid set each time.
- Wrap: write cmd 0x7F plus two data bytes -> writes at 7F then 00. Repeat with AUTO_INC=0 -> both writes at 7F.
- Overrun: data byte arrives while reg_ack withheld -> byte dropped, err_overrun=1. clr_err clears it; a set in the same cycle as clr_err keeps it 1.
- Timeout: read cmd with reg_ack never given -> reg_req low after 15 cycles, err_timeout=1, later bytes of the frame ignored, next frame works normally.
- Mid-operation: spi_busy deasserted during RD_HOLD -> tx_data=0xA5, tx_valid=0, frame_done pulse. Reset asserted mid-write -> all outputs at reset values immediately, asynchronously.

Source files
------------

// File: rtl/spi_reg_ctrl.sv
// SPI frame transaction controller: parses command/data bytes from the SPI slave
// and sequences single-beat register bus writes and read prefetches.
module spi_reg_ctrl #(
   parameter bit          AUTO_INC = 1'b1,
   parameter int unsigned TIMEOUT  = 15,
   parameter logic [7:0]  IDLE_TX  = 8'hA5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       spi_busy,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic [6:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_we,
   output logic       reg_req,
   input  logic       reg_ack,
   input  logic [7:0] reg_rdata,
   input  logic       clr_err,
   output logic       err_overrun,
   output logic       err_timeout,
   output logic       frame_done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_WR_DATA,
      S_WR_BUS,
      S_RD_BUS,
      S_RD_HOLD
   } state_t;

   localparam logic [3:0] TMO_LAST = 4'(TIMEOUT - 1);

   state_t     state_q, state_d;
   logic       busy_q;
   logic [3:0] tmo_q, tmo_d;
   logic [7:0] tx_data_d, wdata_d;
   logic [6:0] addr_d, addr_next;
   logic       tx_valid_d, we_d, req_d, ovr_d, tmo_err_d, done_d;
   logic       busy_rise, busy_fall;
   logic       req_done, req_expire, set_ovr, set_tmo;

   assign busy_rise  = spi_busy & ~busy_q;
   assign busy_fall  = ~spi_busy & busy_q;
   assign req_done   = reg_req & reg_ack;
   assign req_expire = reg_req & ~reg_ack & (tmo_q == TMO_LAST);
   assign addr_next  = AUTO_INC ? reg_addr + 7'd1 : reg_addr;

   // NOTE: every signal written here gets a default first so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      tmo_d      = tmo_q;
      tx_data_d  = tx_data;
      tx_valid_d = tx_valid;
      addr_d     = reg_addr;
      wdata_d    = reg_wdata;
      we_d       = reg_we;
      req_d      = reg_req;
      done_d     = 1'b0;
      set_ovr    = 1'b0;
      set_tmo    = req_expire;

      // A request lives until ack or timeout, independent of frame boundaries.
      if (reg_req) begin
         if (reg_ack || req_expire) req_d = 1'b0;
         else                       tmo_d = tmo_q + 4'd1;
      end

      if (busy_fall) begin
         state_d    = S_IDLE;
         done_d     = 1'b1;
         tx_valid_d = 1'b0;
         tx_data_d  = IDLE_TX;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               tx_data_d  = IDLE_TX;
               tx_valid_d = 1'b0;
               if (busy_rise) state_d = S_CMD;
            end
            S_CMD: begin
               if (rx_valid) begin
                  // A leftover request from the previous frame blocks the command.
                  if (reg_req) begin
                     set_ovr = 1'b1;
                  end else begin
                     addr_d = rx_data[6:0];
                     if (rx_data[7]) begin
                        req_d   = 1'b1;
                        we_d    = 1'b0;
                        tmo_d   = '0;
                        state_d = S_RD_BUS;
                     end else begin
                        state_d = S_WR_DATA;
                     end
                  end
               end
            end
            S_WR_DATA: begin
               if (rx_valid) begin
                  wdata_d = rx_data;
                  req_d   = 1'b1;
                  we_d    = 1'b1;
                  tmo_d   = '0;
                  state_d = S_WR_BUS;
               end
            end
            S_WR_BUS: begin
               if (rx_valid) set_ovr = 1'b1;
               if (req_done) begin
                  addr_d  = addr_next;
                  state_d = S_WR_DATA;
               end else if (req_expire) begin
                  state_d = S_IDLE;
               end
            end
            S_RD_BUS: begin
               if (req_done) begin
                  tx_data_d  = reg_rdata;
                  tx_valid_d = 1'b1;
                  state_d    = S_RD_HOLD;
               end else if (req_expire) begin
                  state_d = S_IDLE;
               end
            end
            S_RD_HOLD: begin
               if (tx_ready) begin
                  tx_valid_d = 1'b0;
                  addr_d     = addr_next;
                  req_d      = 1'b1;
                  we_d       = 1'b0;
                  tmo_d      = '0;
                  state_d    = S_RD_BUS;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      // Sticky flags: a new error outranks a simultaneous clear.
      ovr_d     = set_ovr ? 1'b1 : (clr_err ? 1'b0 : err_overrun);
      tmo_err_d = set_tmo ? 1'b1 : (clr_err ? 1'b0 : err_timeout);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         busy_q      <= 1'b0;
         tmo_q       <= '0;
         tx_data     <= IDLE_TX;
         tx_valid    <= 1'b0;
         reg_addr    <= '0;
         reg_wdata   <= '0;
         reg_we      <= 1'b0;
         reg_req     <= 1'b0;
         err_overrun <= 1'b0;
         err_timeout <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         state_q     <= state_d;
         busy_q      <= spi_busy;
         tmo_q       <= tmo_d;
         tx_data     <= tx_data_d;
         tx_valid    <= tx_valid_d;
         reg_addr    <= addr_d;
         reg_wdata   <= wdata_d;
         reg_we      <= we_d;
         reg_req     <= req_d;
         err_overrun <= ovr_d;
         err_timeout <= tmo_err_d;
         frame_done  <= done_d;
      end
   end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Scoreboard bench for spi_reg_ctrl: one auto-increment and one fixed-address
// instance share SPI stimulus; bus requests and read data are checked against a frame model.
`timescale 1ns/1ps
module tb_spi_reg_ctrl;

   localparam int GAP = 16;

   typedef struct packed {
      logic       we;
      logic [6:0] addr;
      logic [7:0] wdata;
   } bus_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       spi_busy = 1'b0;
   logic       rx_valid = 1'b0;
   logic       tx_ready = 1'b0;
   logic       clr_err = 1'b0;
   logic [7:0] rx_data = 8'h00;

   logic [7:0] tx_data     [2];
   logic       tx_valid    [2];
   logic [6:0] reg_addr    [2];
   logic [7:0] reg_wdata   [2];
   logic       reg_we      [2];
   logic       reg_req     [2];
   logic       reg_ack     [2];
   logic [7:0] reg_rdata   [2];
   logic       err_overrun [2];
   logic       err_timeout [2];
   logic       frame_done  [2];

   int   errors = 0;
   int   checks = 0;
   int   ack_delay = 2;
   bit   ack_block = 1'b0;
   int   frames_seen [2];
   int   frames_exp = 0;
   bus_t       exp_bus [2][$];
   logic [7:0] exp_tx  [2][$];
   logic [7:0] wr_bytes[$];

   always #5 clk = ~clk;

   spi_reg_ctrl #(.AUTO_INC(1'b1), .TIMEOUT(15), .IDLE_TX(8'hA5)) u_inc (
      .clk(clk), .rst_n(rst_n), .spi_busy(spi_busy), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready),
      .reg_addr(reg_addr[0]), .reg_wdata(reg_wdata[0]), .reg_we(reg_we[0]), .reg_req(reg_req[0]),
      .reg_ack(reg_ack[0]), .reg_rdata(reg_rdata[0]), .clr_err(clr_err),
      .err_overrun(err_overrun[0]), .err_timeout(err_timeout[0]), .frame_done(frame_done[0])
   );

   spi_reg_ctrl #(.AUTO_INC(1'b0), .TIMEOUT(15), .IDLE_TX(8'hA5)) u_fix (
      .clk(clk), .rst_n(rst_n), .spi_busy(spi_busy), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready),
      .reg_addr(reg_addr[1]), .reg_wdata(reg_wdata[1]), .reg_we(reg_we[1]), .reg_req(reg_req[1]),
      .reg_ack(reg_ack[1]), .reg_rdata(reg_rdata[1]), .clr_err(clr_err),
      .err_overrun(err_overrun[1]), .err_timeout(err_timeout[1]), .frame_done(frame_done[1])
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Register-bus slave: acks after ack_delay cycles, read data = address ^ 0x3C.
   initial begin : responder
      int cnt [2];
      for (int g = 0; g < 2; g++) begin
         cnt[g] = 0;
         reg_ack[g] = 1'b0;
         reg_rdata[g] = 8'h00;
      end
      forever begin
         @(posedge clk);
         #1;
         for (int g = 0; g < 2; g++) begin
            reg_ack[g] = 1'b0;
            if (reg_req[g] === 1'b1 && !ack_block) begin
               if (cnt[g] >= ack_delay) begin
                  reg_ack[g] = 1'b1;
                  reg_rdata[g] = {1'b0, reg_addr[g]} ^ 8'h3C;
                  cnt[g] = 0;
               end else begin
                  cnt[g]++;
               end
            end else begin
               cnt[g] = 0;
            end
         end
      end
   end

   // Monitor: pops the scoreboard on each new request and each fresh tx byte.
   initial begin : monitor
      logic req_prev [2];
      logic txv_prev [2];
      bus_t e;
      logic [7:0] t;
      for (int g = 0; g < 2; g++) begin
         req_prev[g] = 1'b0;
         txv_prev[g] = 1'b0;
         frames_seen[g] = 0;
      end
      forever begin
         @(negedge clk);
         for (int g = 0; g < 2; g++) begin
            if (reg_req[g] === 1'b1 && !req_prev[g]) begin
               if (exp_bus[g].size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_req[%0d]: got addr=%0h we=%0b, expected no request",
                           g, reg_addr[g], reg_we[g]);
               end else begin
                  e = exp_bus[g].pop_front();
                  check($sformatf("req_we[%0d]", g), 32'(reg_we[g]), 32'(e.we));
                  check($sformatf("req_addr[%0d]", g), 32'(reg_addr[g]), 32'(e.addr));
                  if (e.we) check($sformatf("req_wdata[%0d]", g), 32'(reg_wdata[g]), 32'(e.wdata));
               end
            end
            if (tx_valid[g] === 1'b1 && !txv_prev[g]) begin
               if (exp_tx[g].size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_tx[%0d]: got %0h, expected no tx byte", g, tx_data[g]);
               end else begin
                  t = exp_tx[g].pop_front();
                  check($sformatf("tx_data[%0d]", g), 32'(tx_data[g]), 32'(t));
               end
            end
            if (frame_done[g] === 1'b1) frames_seen[g]++;
            req_prev[g] = (reg_req[g] === 1'b1);
            txv_prev[g] = (tx_valid[g] === 1'b1);
         end
      end
   end

   initial begin : watchdog
      #500_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog expired");
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap = GAP);
      rx_data = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      tick(gap);
   endtask

   task automatic frame_start();
      spi_busy = 1'b1;
      tick(3);
   endtask

   task automatic frame_end();
      spi_busy = 1'b0;
      frames_exp++;
      tick(4);
   endtask

   // Model: address of data beat i for instance g (g=0 increments mod 128, g=1 fixed).
   function automatic logic [6:0] beat_addr(input int g, input logic [6:0] base, input int i);
      return (g == 0) ? 7'((int'(base) + i) % 128) : base;
   endfunction

   task automatic write_frame(input logic [6:0] base);
      frame_start();
      send_byte({1'b0, base});
      for (int i = 0; i < wr_bytes.size(); i++) begin
         for (int g = 0; g < 2; g++) exp_bus[g].push_back({1'b1, beat_addr(g, base, i), wr_bytes[i]});
         send_byte(wr_bytes[i]);
      end
      frame_end();
   endtask

   task automatic read_frame(input logic [6:0] base, input int n_ready);
      frame_start();
      for (int i = 0; i <= n_ready; i++)
         for (int g = 0; g < 2; g++) begin
            exp_bus[g].push_back({1'b0, beat_addr(g, base, i), 8'h00});
            exp_tx[g].push_back({1'b0, beat_addr(g, base, i)} ^ 8'h3C);
         end
      send_byte({1'b1, base});
      for (int i = 0; i < n_ready; i++) begin
         // The slave latches tx_data and clocks in a dummy byte at the same time.
         tx_ready = 1'b1;
         rx_valid = 1'b1;
         rx_data = 8'($urandom);
         tick();
         tx_ready = 1'b0;
         rx_valid = 1'b0;
         tick(GAP);
      end
      frame_end();
   endtask

   task automatic check_errs(input string tag, input logic ovr, input logic tmo);
      for (int g = 0; g < 2; g++) begin
         check($sformatf("%s_ovr[%0d]", tag, g), 32'(err_overrun[g]), 32'(ovr));
         check($sformatf("%s_tmo[%0d]", tag, g), 32'(err_timeout[g]), 32'(tmo));
      end
   endtask

   task automatic check_reset_state(input string tag);
      for (int g = 0; g < 2; g++) begin
         check($sformatf("%s_tx_data[%0d]", tag, g), 32'(tx_data[g]), 32'h0A5);
         check($sformatf("%s_tx_valid[%0d]", tag, g), 32'(tx_valid[g]), 32'h0);
         check($sformatf("%s_addr[%0d]", tag, g), 32'(reg_addr[g]), 32'h0);
         check($sformatf("%s_wdata[%0d]", tag, g), 32'(reg_wdata[g]), 32'h0);
         check($sformatf("%s_we[%0d]", tag, g), 32'(reg_we[g]), 32'h0);
         check($sformatf("%s_req[%0d]", tag, g), 32'(reg_req[g]), 32'h0);
         check($sformatf("%s_done[%0d]", tag, g), 32'(frame_done[g]), 32'h0);
      end
      check_errs(tag, 1'b0, 1'b0);
   endtask

   initial begin : stimulus
      int n;
      logic [6:0] base;

      tick(3);
      check_reset_state("reset");
      rst_n = 1'b1;
      tick(2);

      // Write burst 05: 11, 22
      ack_delay = 2;
      wr_bytes = '{8'h11, 8'h22};
      write_frame(7'h05);
      check("write_frames", 32'(frames_seen[0]), 32'(frames_exp));
      check_errs("write", 1'b0, 1'b0);

      // Read burst 85 with two tx_ready pulses
      read_frame(7'h05, 2);
      check_errs("read", 1'b0, 1'b0);

      // Address wrap at 7F
      wr_bytes = '{8'h5A, 8'hC3};
      write_frame(7'h7F);

      // Overrun, clear, and set-wins-over-clear
      ack_delay = 1;
      ack_block = 1'b1;
      frame_start();
      send_byte(8'h10);
      for (int g = 0; g < 2; g++) exp_bus[g].push_back({1'b1, 7'h10, 8'h55});
      send_byte(8'h55, 2);
      send_byte(8'h66, 0);
      check_errs("overrun_set", 1'b1, 1'b0);
      check("overrun_wdata", 32'(reg_wdata[0]), 32'h55);
      ack_block = 1'b0;
      tick(GAP);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      check_errs("overrun_clr", 1'b0, 1'b0);
      ack_block = 1'b1;
      for (int g = 0; g < 2; g++) exp_bus[g].push_back({1'b1, beat_addr(g, 7'h10, 1), 8'h77});
      send_byte(8'h77, 2);
      rx_data = 8'h88;
      rx_valid = 1'b1;
      clr_err = 1'b1;
      tick();
      rx_valid = 1'b0;
      clr_err = 1'b0;
      check_errs("overrun_vs_clr", 1'b1, 1'b0);
      ack_block = 1'b0;
      tick(GAP);
      frame_end();
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;

      // Timeout on a read that is never acknowledged
      ack_block = 1'b1;
      frame_start();
      for (int g = 0; g < 2; g++) exp_bus[g].push_back({1'b0, 7'h10, 8'h00});
      rx_data = 8'h90;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      n = 0;
      while (reg_req[0] === 1'b1 && n < 40) begin
         tick();
         n++;
      end
      check("timeout_len", 32'(n), 32'd15);
      check("timeout_req_fix", 32'(reg_req[1]), 32'h0);
      check_errs("timeout", 1'b0, 1'b1);
      ack_block = 1'b0;
      send_byte(8'h05);
      send_byte(8'h33);
      frame_end();
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      check_errs("timeout_clr", 1'b0, 1'b0);
      wr_bytes = '{8'hAB};
      write_frame(7'h20);

      // Frame end while read data is held
      frame_start();
      for (int g = 0; g < 2; g++) begin
         exp_bus[g].push_back({1'b0, 7'h05, 8'h00});
         exp_tx[g].push_back(8'h39);
      end
      send_byte(8'h85);
      check("hold_tx_valid", 32'(tx_valid[0]), 32'h1);
      spi_busy = 1'b0;
      frames_exp++;
      tick();
      for (int g = 0; g < 2; g++) begin
         check($sformatf("abort_tx_data[%0d]", g), 32'(tx_data[g]), 32'h0A5);
         check($sformatf("abort_tx_valid[%0d]", g), 32'(tx_valid[g]), 32'h0);
         check($sformatf("abort_done[%0d]", g), 32'(frame_done[g]), 32'h1);
      end
      tick();
      check("abort_done_pulse", 32'(frame_done[0]), 32'h0);
      tick(3);

      // Randomised frames
      for (int it = 0; it < 10; it++) begin
         ack_delay = $urandom_range(0, 3);
         base = 7'($urandom_range(0, 127));
         if ($urandom_range(0, 1) == 1) begin
            wr_bytes.delete();
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) wr_bytes.push_back(8'($urandom));
            write_frame(base);
         end else begin
            read_frame(base, $urandom_range(0, 3));
         end
      end
      check_errs("random", 1'b0, 1'b0);

      // Asynchronous reset in the middle of an outstanding write
      ack_block = 1'b1;
      frame_start();
      send_byte(8'h30);
      for (int g = 0; g < 2; g++) exp_bus[g].push_back({1'b1, 7'h30, 8'h44});
      send_byte(8'h44, 2);
      check("pre_reset_req", 32'(reg_req[0]), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_state("async_reset");
      spi_busy = 1'b0;
      ack_block = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(2);
      wr_bytes = '{8'hE1};
      write_frame(7'h40);

      for (int g = 0; g < 2; g++) begin
         check($sformatf("bus_queue_empty[%0d]", g), 32'(exp_bus[g].size()), 32'd0);
         check($sformatf("tx_queue_empty[%0d]", g), 32'(exp_tx[g].size()), 32'd0);
         check($sformatf("frame_count[%0d]", g), 32'(frames_seen[g]), 32'(frames_exp));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
